// File: rtl/microc_pkg.sv
// Shared constants for the microc_stk datapath: ALU op encodings and instruction geometry.
// Optional carry flag is enabled by defining MICROC_CARRY_EN.
package microc_pkg;

  localparam int unsigned OPC_W = 6;

  localparam logic [2:0] ALU_A    = 3'b000;
  localparam logic [2:0] ALU_NOTA = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_OR   = 3'b101;
  localparam logic [2:0] ALU_NEGA = 3'b110;
  localparam logic [2:0] ALU_NEGB = 3'b111;

  // Opcode plus three register-address fields.
  function automatic int unsigned instr_w(input int unsigned ra_w);
    return OPC_W + 3 * ra_w;
  endfunction

endpackage

// File: rtl/microc_stk_if.sv
// Control-unit <-> datapath bundle for microc_stk; carries port c when MICROC_CARRY_EN is defined.
interface microc_stk_if #(
  parameter int unsigned RA_W = 4,
  parameter int unsigned PC_W = 10
) ();
  import microc_pkg::*;

  localparam int unsigned INSTR_W = instr_w(RA_W);

  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    pc;
  logic [OPC_W-1:0]   opcode;
  logic               z;
  logic               s_inc;
  logic               s_inm;
  logic               we3;
  logic               wez;
  logic [2:0]         op;
  logic               push;
  logic               pop;
  logic               stk_full;
  logic               stk_empty;
  logic               stk_err;
`ifdef MICROC_CARRY_EN
  logic               c;

  modport master (output instr, s_inc, s_inm, we3, wez, op, push, pop,
                  input  pc, opcode, z, stk_full, stk_empty, stk_err, c);
  modport slave  (input  instr, s_inc, s_inm, we3, wez, op, push, pop,
                  output pc, opcode, z, stk_full, stk_empty, stk_err, c);
`else
  modport master (output instr, s_inc, s_inm, we3, wez, op, push, pop,
                  input  pc, opcode, z, stk_full, stk_empty, stk_err);
  modport slave  (input  instr, s_inc, s_inm, we3, wez, op, push, pop,
                  output pc, opcode, z, stk_full, stk_empty, stk_err);
`endif

endinterface

// File: rtl/microc_retstack.sv
// Hardware return-address LIFO; pop wins over push, misuse sets a sticky error until reset.
module microc_retstack #(
  parameter int unsigned PC_W        = 10,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] din,
  output logic [PC_W-1:0] top,
  output logic            full,
  output logic            empty,
  output logic            err
);

  localparam int unsigned PTR_W = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(STACK_DEPTH);

  logic [PC_W-1:0]  mem [STACK_DEPTH];
  logic [PTR_W-1:0] ptr;

  assign full  = (ptr == PTR_W'(STACK_DEPTH));
  assign empty = (ptr == '0);
  assign top   = mem[IDX_W'(ptr - PTR_W'(1))];

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
      err <= 1'b0;
    end else if (pop) begin
      if (empty) err <= 1'b1;
      else       ptr <= ptr - PTR_W'(1);
    end else if (push) begin
      if (full) err <= 1'b1;
      else      ptr <= ptr + PTR_W'(1);
    end
  end

  // Entry storage needs no reset; the pointer alone defines validity.
  always_ff @(posedge clk) begin
    if (!reset && push && !pop && !full)
      mem[IDX_W'(ptr)] <= din;
  end

endmodule

// File: rtl/microc_stk.sv
// Single-cycle microcontroller datapath with CALL/RET return stack.
// Define MICROC_CARRY_EN to add the carry/borrow flag c.
module microc_stk
  import microc_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned RA_W        = 4,
  parameter int unsigned PC_W        = 10,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  microc_stk_if.slave  bus
);

  localparam int unsigned INSTR_W = instr_w(RA_W);
  localparam int unsigned NREG    = 2 ** RA_W;

  logic [RA_W-1:0]   wa, ra1, ra2;
  logic [DATA_W-1:0] imm, rd1, rd2, alu, wd;
  logic [PC_W-1:0]   target, pc_q, pc_inc, pc_nx, stk_top;
  logic              z_q, stk_full, stk_empty, stk_err;
  logic [DATA_W-1:0] rf [NREG];

  assign wa          = bus.instr[RA_W-1:0];
  assign ra2         = bus.instr[2*RA_W-1:RA_W];
  assign ra1         = bus.instr[3*RA_W-1:2*RA_W];
  assign imm         = bus.instr[RA_W+DATA_W-1:RA_W];
  assign target      = bus.instr[PC_W-1:0];
  assign bus.opcode  = bus.instr[INSTR_W-1 -: OPC_W];

  // R0 is hardwired to zero on reads; writes to it are dropped.
  assign rd1 = (ra1 == '0) ? '0 : rf[ra1];
  assign rd2 = (ra2 == '0) ? '0 : rf[ra2];
  assign wd  = bus.s_inm ? imm : alu;

  always_ff @(posedge clk) begin
    if (bus.we3 && wa != '0)
      rf[wa] <= wd;
  end

  always_comb begin
    alu = '0;
    case (bus.op)
      ALU_A:    alu = rd1;
      ALU_NOTA: alu = ~rd1;
      ALU_ADD:  alu = rd1 + rd2;
      ALU_SUB:  alu = rd1 - rd2;
      ALU_AND:  alu = rd1 & rd2;
      ALU_OR:   alu = rd1 | rd2;
      ALU_NEGA: alu = DATA_W'(0) - rd1;
      ALU_NEGB: alu = DATA_W'(0) - rd2;
      default:  alu = '0;
    endcase
  end

  microc_retstack #(
    .PC_W        (PC_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_retstack (
    .clk   (clk),
    .reset (reset),
    .push  (bus.push),
    .pop   (bus.pop),
    .din   (pc_inc),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty),
    .err   (stk_err)
  );

  assign pc_inc = pc_q + PC_W'(1);

  // RET outranks CALL; an underflowing RET falls through to pc+1.
  always_comb begin
    pc_nx = bus.s_inc ? pc_inc : target;
    if (bus.pop)       pc_nx = stk_empty ? pc_inc : stk_top;
    else if (bus.push) pc_nx = target;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= '0;
      z_q  <= 1'b0;
    end else begin
      pc_q <= pc_nx;
      if (bus.wez) z_q <= (alu == '0);
    end
  end

`ifdef MICROC_CARRY_EN
  logic [DATA_W:0] sum_ext;
  logic            c_q, c_nx;

  assign sum_ext = {1'b0, rd1} + {1'b0, rd2};

  always_comb begin
    c_nx = 1'b0;
    if (bus.op == ALU_ADD)      c_nx = sum_ext[DATA_W];
    else if (bus.op == ALU_SUB) c_nx = (rd1 < rd2);
  end

  always_ff @(posedge clk) begin
    if (reset)        c_q <= 1'b0;
    else if (bus.wez) c_q <= c_nx;
  end

  assign bus.c = c_q;
`endif

  assign bus.pc        = pc_q;
  assign bus.z         = z_q;
  assign bus.stk_full  = stk_full;
  assign bus.stk_empty = stk_empty;
  assign bus.stk_err   = stk_err;

endmodule

// File: tb/tb_microc_stk.sv
// Directed + randomized bench for microc_stk against a queue/array reference model.
module tb_microc_stk;
  import microc_pkg::*;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned RA_W    = 4;
  localparam int unsigned PC_W    = 10;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned INSTR_W = 6 + 3 * RA_W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  microc_stk_if #(.RA_W(RA_W), .PC_W(PC_W)) bus ();

  microc_stk #(
    .DATA_W(DATA_W), .RA_W(RA_W), .PC_W(PC_W), .STACK_DEPTH(DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int passed = 0;
  int total  = 0;

  int m_rf[16];
  int m_pc, m_z, m_c, m_err;
  int m_stk[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic int alu_ref(input int o, input int a, input int b);
    case (o)
      0: return a;
      1: return (255 - a);
      2: return (a + b) % 256;
      3: return (a - b + 256) % 256;
      4: return a & b;
      5: return a | b;
      6: return (256 - a) % 256;
      default: return (256 - b) % 256;
    endcase
  endfunction

  function automatic logic [INSTR_W-1:0] f_reg(input int ra1, input int ra2, input int wa);
    return INSTR_W'((ra1 << 8) | (ra2 << 4) | wa);
  endfunction

  function automatic logic [INSTR_W-1:0] f_imm(input int imm, input int wa);
    return INSTR_W'((1 << 12) | (imm << 4) | wa);
  endfunction

  function automatic logic [INSTR_W-1:0] f_tgt(input int t);
    return INSTR_W'((2 << 12) | t);
  endfunction

  // Reference model for one clock edge, then DUT comparison just after it.
  task automatic tick();
    int ins, wa, ra2, ra1, imm, tgt, a, b, r, o;
    ins = 32'(bus.instr);
    wa  = ins % 16;
    ra2 = (ins / 16) % 16;
    ra1 = (ins / 256) % 16;
    imm = (ins / 16) % 256;
    tgt = ins % 1024;
    o   = 32'(bus.op);
    a   = (ra1 == 0) ? 0 : m_rf[ra1];
    b   = (ra2 == 0) ? 0 : m_rf[ra2];
    r   = alu_ref(o, a, b);
    if (bus.we3 && wa != 0) m_rf[wa] = bus.s_inm ? imm : r;
    if (reset) begin
      m_pc = 0; m_z = 0; m_c = 0; m_err = 0;
      m_stk.delete();
    end else begin
      if (bus.wez) begin
        m_z = (r == 0) ? 1 : 0;
        m_c = (o == 2) ? ((a + b > 255) ? 1 : 0) : (o == 3) ? ((a < b) ? 1 : 0) : 0;
      end
      if (bus.pop) begin
        if (m_stk.size() > 0) m_pc = m_stk.pop_back();
        else begin m_pc = (m_pc + 1) % 1024; m_err = 1; end
      end else if (bus.push) begin
        if (m_stk.size() < DEPTH) m_stk.push_back((m_pc + 1) % 1024);
        else m_err = 1;
        m_pc = tgt;
      end else begin
        m_pc = bus.s_inc ? (m_pc + 1) % 1024 : tgt;
      end
    end
    @(posedge clk);
    #1;
    chk("pc", 32'(bus.pc), m_pc);
    chk("z", 32'(bus.z), m_z);
    chk("stk_full", 32'(bus.stk_full), (m_stk.size() == DEPTH) ? 1 : 0);
    chk("stk_empty", 32'(bus.stk_empty), (m_stk.size() == 0) ? 1 : 0);
    chk("stk_err", 32'(bus.stk_err), m_err);
    chk("opcode", 32'(bus.opcode), ins / 4096);
`ifdef MICROC_CARRY_EN
    chk("c", 32'(bus.c), m_c);
`endif
  endtask

  task automatic cyc(input logic [INSTR_W-1:0] i, input bit inc, input bit inm, input bit we,
                     input bit wz, input logic [2:0] o, input bit pu, input bit po);
    bus.instr = i; bus.s_inc = inc; bus.s_inm = inm; bus.we3 = we;
    bus.wez = wz; bus.op = o; bus.push = pu; bus.pop = po;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(f_tgt(0), 1, 0, 0, 0, ALU_A, 0, 0);
    reset = 1'b0;
  endtask

  initial begin
    int pops[4];
    pops = '{32'h061, 32'h041, 32'h021, 32'h012};
    foreach (m_rf[k]) m_rf[k] = 0;
    m_pc = 0; m_z = 0; m_c = 0; m_err = 0;
    reset = 1'b0;
    do_reset();

    // Reset from a non-zero pc
    cyc(f_tgt(32'h155), 0, 0, 0, 0, ALU_A, 0, 0);
    chk("jump_155", 32'(bus.pc), 32'h155);
    do_reset();
    chk("rst_pc", 32'(bus.pc), 0);
    chk("rst_z", 32'(bus.z), 0);
    chk("rst_empty", 32'(bus.stk_empty), 1);
    chk("rst_err", 32'(bus.stk_err), 0);

    // Immediate loads and SUB/ADD flags
    cyc(f_imm(5, 1), 1, 1, 1, 0, ALU_A, 0, 0);
    cyc(f_imm(5, 2), 1, 1, 1, 0, ALU_A, 0, 0);
    cyc(f_reg(1, 2, 3), 1, 0, 1, 1, ALU_SUB, 0, 0);
    chk("sub_z", 32'(bus.z), 1);
    cyc(f_reg(1, 2, 3), 1, 0, 1, 1, ALU_ADD, 0, 0);
    chk("add_z", 32'(bus.z), 0);
    cyc(f_imm(32'h0A, 4), 1, 1, 1, 0, ALU_A, 0, 0);
    chk("imm_keeps_z", 32'(bus.z), 0);
    cyc(f_reg(3, 4, 0), 1, 0, 0, 1, ALU_SUB, 0, 0);
    chk("r3_is_0a", 32'(bus.z), 1);

    // CALL/RET round trip
    cyc(f_tgt(32'h010), 0, 0, 0, 0, ALU_A, 0, 0);
    cyc(f_tgt(32'h100), 1, 0, 0, 0, ALU_A, 1, 0);
    chk("call_pc", 32'(bus.pc), 32'h100);
    cyc(f_tgt(0), 1, 0, 0, 0, ALU_A, 0, 1);
    chk("ret_pc", 32'(bus.pc), 32'h011);
    chk("ret_empty", 32'(bus.stk_empty), 1);

    // Fill, overflow, drain in LIFO order
    for (int k = 1; k <= 5; k++) begin
      cyc(f_tgt(k * 32'h20), 1, 0, 0, 0, ALU_A, 1, 0);
      if (k == 4) chk("full_at_4", 32'(bus.stk_full), 1);
      if (k == 4) chk("no_err_at_4", 32'(bus.stk_err), 0);
    end
    chk("ovf_err", 32'(bus.stk_err), 1);
    chk("ovf_pc", 32'(bus.pc), 32'h0A0);
    for (int k = 0; k < 4; k++) begin
      cyc(f_tgt(0), 1, 0, 0, 0, ALU_A, 0, 1);
      chk("lifo_pc", 32'(bus.pc), pops[k]);
    end
    chk("drained", 32'(bus.stk_empty), 1);

    // Underflow at pc wrap, then simultaneous push+pop
    do_reset();
    cyc(f_tgt(32'h3FF), 0, 0, 0, 0, ALU_A, 0, 0);
    cyc(f_tgt(0), 1, 0, 0, 0, ALU_A, 0, 1);
    chk("unf_wrap_pc", 32'(bus.pc), 0);
    chk("unf_err", 32'(bus.stk_err), 1);
    do_reset();
    cyc(f_tgt(32'h050), 1, 0, 0, 0, ALU_A, 1, 0);
    cyc(f_tgt(32'h200), 1, 0, 0, 0, ALU_A, 1, 1);
    chk("pushpop_pc", 32'(bus.pc), 32'h001);
    chk("pushpop_empty", 32'(bus.stk_empty), 1);
    chk("pushpop_err", 32'(bus.stk_err), 0);

    // R0 ignores writes
    cyc(f_imm(32'h55, 0), 1, 1, 1, 0, ALU_A, 0, 0);
    cyc(f_reg(0, 0, 0), 1, 0, 0, 1, ALU_A, 0, 0);
    chk("r0_zero", 32'(bus.z), 1);

`ifdef MICROC_CARRY_EN
    cyc(f_imm(32'hFF, 5), 1, 1, 1, 0, ALU_A, 0, 0);
    cyc(f_imm(32'h01, 6), 1, 1, 1, 0, ALU_A, 0, 0);
    cyc(f_imm(32'h02, 7), 1, 1, 1, 0, ALU_A, 0, 0);
    cyc(f_reg(5, 6, 8), 1, 0, 1, 1, ALU_ADD, 0, 0);
    chk("add_carry_z", 32'(bus.z), 1);
    chk("add_carry_c", 32'(bus.c), 1);
    cyc(f_reg(6, 7, 8), 1, 0, 1, 1, ALU_SUB, 0, 0);
    chk("sub_borrow_c", 32'(bus.c), 1);
    chk("sub_borrow_z", 32'(bus.z), 0);
`endif

    // Give every register a known value before random traffic
    for (int r = 1; r < 16; r++)
      cyc(f_imm(int'($urandom_range(0, 255)), r), 1, 1, 1, 0, ALU_A, 0, 0);

    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 49) == 0);
      cyc(INSTR_W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          3'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 6) == 0));
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
